dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameters SHALL be: LINE_SIZE, default 16, bytes per line (power of 2, >=8); CACHE_SIZE, default 256, total data bytes (power of 2, multiple of LINE_SIZE); XLEN, default 32, address/word width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pipe_req_address  in  XLEN  byte address.
- pipe_req_size  in  memory_operation_size_e  BYTE/HALF/WORD.
- pipe_req_type  in  memory_operation_e  LOAD/STORE.
- pipe_req_valid  in  1  request present; held until fulfilled.
- pipe_word_to_store  in  XLEN  store data, right-justified.
- pipe_fetched_word  out  XLEN  load data, zero-extended.
- pipe_req_fulfilled  out  1  request completes this cycle.
- l2_req_address  out  XLEN  word-aligned L2 address.
- l2_req_type  out  memory_operation_e  LOAD (fill) / STORE (writeback).
- l2_req_valid  out  1  L2 request present.
- l2_word_to_store  out  XLEN  writeback word.
- l2_fetched_word  in  XLEN  fill word.
- l2_req_fulfilled  in  1  L2 completes the current word this cycle (may be combinational on l2_req_valid).

Function
REQ-003 Organisation SHALL be direct-mapped, write-back, write-allocate: NUM_LINES = CACHE_SIZE/LINE_SIZE; address = {tag, index, word offset, byte offset[1:0]}; per line one valid bit, one dirty bit, one tag.
REQ-004 States SHALL be COMPARE, WRITEBACK and ALLOCATE.
REQ-005 In COMPARE with pipe_req_valid=1, a hit (valid && tag match) SHALL assert pipe_req_fulfilled combinationally in the same cycle.
REQ-006 Load data SHALL be (word >> 8*addr[1:0]) masked to 8/16/32 bits for BYTE/HALF/WORD, upper bits zero.
REQ-007 On a store hit, the addressed byte(s) SHALL be written at the clock edge ending the fulfilled cycle and the line's dirty bit set.
REQ-008 Alignment: HALF ignores addr[0]; WORD ignores addr[1:0].
REQ-009 A COMPARE miss SHALL go to WRITEBACK if the victim line is valid and dirty, otherwise to ALLOCATE; pipe_req_fulfilled=0 during the miss.
REQ-010 WRITEBACK SHALL issue LINE_SIZE/4 word STOREs at {victim tag, index, word k, 2'b00} for k=0,1,..., advancing k on each cycle with l2_req_fulfilled=1, then enter ALLOCATE.
REQ-011 ALLOCATE SHALL issue LINE_SIZE/4 word LOADs at {req tag, index, word k, 2'b00}, capturing l2_fetched_word into word k when l2_req_fulfilled=1; after the last word it SHALL set valid, clear dirty, write the tag and return to COMPARE, where the request hits.
REQ-012 l2_req_valid SHALL be 1 only in WRITEBACK/ALLOCATE; minimum miss latency with a combinational L2 is LINE_SIZE/4+1 cycles clean, 2*LINE_SIZE/4+1 dirty.
REQ-013 pipe_req_valid=0 in COMPARE SHALL cause no state change; a request dropped mid-miss SHALL still complete the line transfer.
REQ-014 Back-to-back requests (new address the cycle after fulfil) SHALL be serviced without idle cycles.

Reset
REQ-015 reset=1 SHALL asynchronously clear all valid and dirty bits, set state COMPARE and word counter 0; outputs pipe_req_fulfilled=0, l2_req_valid=0, l2_req_type=LOAD, l2_req_address=0.
REQ-016 Reset mid-miss SHALL abort the transfer; data array contents need not be reset.

Configuration
REQ-017 With DCACHE_PERF_COUNTERS_EN defined, 32-bit output ports hit_count and miss_count SHALL exist, counting COMPARE hits (fulfilled cycles) and COMPARE-to-miss transitions, cleared by reset and wrapping at 2^32; without the macro these ports and their logic SHALL not exist.

Verification
REQ-018 Reset, LOAD WORD 0x100 with L2 word 0x100=0xDEADBEEF -> 4 L2 LOADs 0x100..0x10C, then fulfilled with 0xDEADBEEF.
REQ-019 Same line, LOAD BYTE 0x103 -> same-cycle hit, 0x000000DE; LOAD HALF 0x102 -> 0x0000DEAD.
REQ-020 STORE BYTE 0x101 data 0x55, then LOAD WORD 0x100 -> 0xDEAD55EF, no L2 traffic.
REQ-021 LOAD WORD 0x200 (same index, dirty victim) -> 4 L2 STOREs 0x100..0x10C with 0xDEAD55EF first, then 4 LOADs 0x200..0x20C.
REQ-022 2048 random LOADs over 2048 word-aligned locations with random sizes/offsets -> zero mismatches within 100000 cycles.
REQ-023 Reset asserted during ALLOCATE -> l2_req_valid=0 immediately; next LOAD to that line misses.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache with a word-wide L2 port.
// Define DCACHE_PERF_COUNTERS_EN to add the hit_count/miss_count outputs.
`timescale 1ns/1ps

package dcache_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_operation_size_e;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

module dcache
  import dcache_pkg::*;
#(
  parameter int LINE_SIZE  = 16,
  parameter int CACHE_SIZE = 256,
  parameter int XLEN       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        pipe_req_address,
  input  memory_operation_size_e pipe_req_size,
  input  memory_operation_e      pipe_req_type,
  input  logic                   pipe_req_valid,
  input  logic [XLEN-1:0]        pipe_word_to_store,
  output logic [XLEN-1:0]        pipe_fetched_word,
  output logic                   pipe_req_fulfilled,
  output logic [XLEN-1:0]        l2_req_address,
  output memory_operation_e      l2_req_type,
  output logic                   l2_req_valid,
  output logic [XLEN-1:0]        l2_word_to_store,
  input  logic [XLEN-1:0]        l2_fetched_word,
  input  logic                   l2_req_fulfilled
`ifdef DCACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);

  localparam int WORDS     = LINE_SIZE / 4;
  localparam int NUM_LINES = CACHE_SIZE / LINE_SIZE;
  localparam int WOFF_W    = $clog2(WORDS);
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int OFF_W     = $clog2(LINE_SIZE);
  localparam int TAG_W     = XLEN - IDX_W - OFF_W;
  localparam int NB        = XLEN / 8;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [WOFF_W-1:0] word_q, word_d;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [XLEN-1:0]      data_mem [NUM_LINES][WORDS];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WOFF_W-1:0] req_woff;
  logic [1:0]        boff;
  logic [XLEN-1:0]   cur_word;
  logic              hit;
  logic              last_word;

  logic            store_hit;
  logic            fill_we;
  logic            fill_done;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata;

  assign req_tag   = pipe_req_address[XLEN-1 -: TAG_W];
  assign req_idx   = pipe_req_address[OFF_W +: IDX_W];
  assign req_woff  = pipe_req_address[2 +: WOFF_W];
  assign boff      = pipe_req_address[1:0];
  assign cur_word  = data_mem[req_idx][req_woff];
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_word = (word_q == WOFF_W'(WORDS - 1));

  always_comb begin
    state_d            = state_q;
    word_d             = word_q;
    miss_tag_d         = miss_tag_q;
    miss_idx_d         = miss_idx_q;
    pipe_req_fulfilled = 1'b0;
    l2_req_valid       = 1'b0;
    l2_req_type        = LOAD;
    l2_req_address     = '0;
    l2_word_to_store   = '0;
    store_hit          = 1'b0;
    fill_we            = 1'b0;
    fill_done          = 1'b0;
    unique case (state_q)
      COMPARE: begin
        if (pipe_req_valid) begin
          if (hit) begin
            pipe_req_fulfilled = 1'b1;
            store_hit = (pipe_req_type == STORE);
          end else begin
            // Latch the miss so a dropped request still finishes the line.
            miss_tag_d = req_tag;
            miss_idx_d = req_idx;
            word_d     = '0;
            if (valid_q[req_idx] && dirty_q[req_idx])
              state_d = WRITEBACK;
            else
              state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        l2_req_valid     = 1'b1;
        l2_req_type      = STORE;
        l2_req_address   = {tag_mem[miss_idx_q], miss_idx_q, word_q, 2'b00};
        l2_word_to_store = data_mem[miss_idx_q][word_q];
        if (l2_req_fulfilled) begin
          word_d = word_q + 1'b1;
          if (last_word) begin
            word_d  = '0;
            state_d = ALLOCATE;
          end
        end
      end
      ALLOCATE: begin
        l2_req_valid   = 1'b1;
        l2_req_type    = LOAD;
        l2_req_address = {miss_tag_q, miss_idx_q, word_q, 2'b00};
        if (l2_req_fulfilled) begin
          fill_we = 1'b1;
          word_d  = word_q + 1'b1;
          if (last_word) begin
            fill_done = 1'b1;
            word_d    = '0;
            state_d   = COMPARE;
          end
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  always_comb begin
    pipe_fetched_word = '0;
    be                = '0;
    wdata             = '0;
    unique case (1'b1)
      pipe_req_size == BYTE: begin
        pipe_fetched_word = XLEN'(cur_word[{boff, 3'b000} +: 8]);
        be    = NB'(1) << boff;
        wdata = {NB{pipe_word_to_store[7:0]}};
      end
      pipe_req_size == HALF: begin
        pipe_fetched_word = XLEN'(cur_word[{boff[1], 4'b0000} +: 16]);
        be    = NB'(3) << {boff[1], 1'b0};
        wdata = {(NB/2){pipe_word_to_store[15:0]}};
      end
      pipe_req_size == WORD: begin
        pipe_fetched_word = cur_word;
        be    = '1;
        wdata = pipe_word_to_store;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= COMPARE;
      word_q     <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      if (fill_done) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done)
      tag_mem[miss_idx_q] <= miss_tag_q;
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[miss_idx_q][word_q] <= l2_fetched_word;
    end else if (store_hit) begin
      for (int b = 0; b < NB; b++)
        if (be[b])
          data_mem[req_idx][req_woff][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

`ifdef DCACHE_PERF_COUNTERS_EN
  logic miss_start;
  assign miss_start = (state_q == COMPARE) && pipe_req_valid && !hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (pipe_req_fulfilled)
        hit_count <= hit_count + 32'd1;
      if (miss_start)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboarded bench for dcache: combinational L2 model, reference memory,
// directed fill/hit/store/writeback/reset scenarios and a random load sweep.
`timescale 1ns/1ps

module tb_dcache;
  import dcache_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [31:0]            pipe_req_address;
  memory_operation_size_e pipe_req_size;
  memory_operation_e      pipe_req_type;
  logic                   pipe_req_valid;
  logic [31:0]            pipe_word_to_store;
  logic [31:0]            pipe_fetched_word;
  logic                   pipe_req_fulfilled;
  logic [31:0]            l2_req_address;
  memory_operation_e      l2_req_type;
  logic                   l2_req_valid;
  logic [31:0]            l2_word_to_store;
  logic [31:0]            l2_fetched_word;
  logic                   l2_req_fulfilled;
`ifdef DCACHE_PERF_COUNTERS_EN
  logic [31:0]            hit_count;
  logic [31:0]            miss_count;
`endif

  dcache #(.LINE_SIZE(16), .CACHE_SIZE(256), .XLEN(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .pipe_req_address   (pipe_req_address),
    .pipe_req_size      (pipe_req_size),
    .pipe_req_type      (pipe_req_type),
    .pipe_req_valid     (pipe_req_valid),
    .pipe_word_to_store (pipe_word_to_store),
    .pipe_fetched_word  (pipe_fetched_word),
    .pipe_req_fulfilled (pipe_req_fulfilled),
    .l2_req_address     (l2_req_address),
    .l2_req_type        (l2_req_type),
    .l2_req_valid       (l2_req_valid),
    .l2_word_to_store   (l2_word_to_store),
    .l2_fetched_word    (l2_fetched_word),
    .l2_req_fulfilled   (l2_req_fulfilled)
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    .hit_count          (hit_count),
    .miss_count         (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
  } l2_txn_t;

  logic [31:0] l2mem  [2048];
  logic [31:0] refmem [2048];
  l2_txn_t     l2_log [$];
  logic [31:0] exp_q  [$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [31:0] pat(int i);
    return (i * 32'h0100_0193) ^ 32'hA5C3_5A3C;
  endfunction

  assign l2_req_fulfilled = l2_req_valid;
  assign l2_fetched_word  = l2mem[l2_req_address[12:2]];

  // L2 memory: one process owns the array and logs every word transfer.
  initial begin
    for (int i = 0; i < 2048; i++) l2mem[i] = pat(i);
    l2mem[64] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (l2_req_valid && l2_req_fulfilled) begin
        l2_log.push_back({l2_req_type == STORE, l2_req_address,
          (l2_req_type == STORE) ? l2_word_to_store : l2mem[l2_req_address[12:2]]});
        if (l2_req_type == STORE) l2mem[l2_req_address[12:2]] = l2_word_to_store;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] ref_load(logic [31:0] a, memory_operation_size_e sz);
    logic [31:0] w;
    w = refmem[a[12:2]];
    case (sz)
      BYTE:    return (w >> (8 * a[1:0])) & 32'h0000_00FF;
      HALF:    return (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic void ref_store(logic [31:0] a, memory_operation_size_e sz, logic [31:0] d);
    int i;
    i = int'(a[12:2]);
    case (sz)
      BYTE:    refmem[i][8*a[1:0] +: 8] = d[7:0];
      HALF:    refmem[i][(a[1] ? 16 : 0) +: 16] = d[15:0];
      default: refmem[i] = d;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after fulfilment.
  task automatic drive_req(input logic [31:0] a, input memory_operation_size_e sz,
                           input memory_operation_e ty, input logic [31:0] wd,
                           output int cyc, output logic [31:0] rd, output bit ok);
    pipe_req_address   = a;
    pipe_req_size      = sz;
    pipe_req_type      = ty;
    pipe_word_to_store = wd;
    pipe_req_valid     = 1'b1;
    ok = 1'b0; cyc = 0; rd = '0;
    while (!ok && cyc < 40) begin
      #4;
      if (pipe_req_fulfilled) begin
        ok = 1'b1;
        rd = pipe_fetched_word;
      end
      @(negedge clk);
      if (!ok) cyc++;
    end
    pipe_req_valid = 1'b0;
  endtask

  task automatic test_reset;
    pipe_req_valid   = 1'b1;
    pipe_req_address = 32'h100;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #4;
    total++; if (pipe_req_fulfilled !== 1'b0) begin bad++; $display("FAIL reset_fulfilled got %b want 0", pipe_req_fulfilled); end
    total++; if (l2_req_valid !== 1'b0) begin bad++; $display("FAIL reset_l2_valid got %b want 0", l2_req_valid); end
    total++; if (l2_req_type !== LOAD) begin bad++; $display("FAIL reset_l2_type got %0d want LOAD", l2_req_type); end
    total++; if (l2_req_address !== 32'h0) begin bad++; $display("FAIL reset_l2_addr got %h want 0", l2_req_address); end
    @(negedge clk);
    pipe_req_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_fill;
    int cyc; logic [31:0] rd, e; bit ok; l2_txn_t t;
    l2_log.delete();
    exp_q.push_back(32'hDEADBEEF);
    drive_req(32'h100, WORD, LOAD, 32'h0, cyc, rd, ok);
    e = exp_q.pop_front();
    total++; if (!ok || rd !== e) begin bad++; $display("FAIL fill_data got %h want %h ok=%0d", rd, e, ok); end
    total++; if (cyc !== 5) begin bad++; $display("FAIL fill_latency got %0d want 5", cyc); end
    total++; if (l2_log.size() !== 4) begin bad++; $display("FAIL fill_l2_count got %0d want 4", l2_log.size()); end
    for (int k = 0; k < 4 && k < l2_log.size(); k++) begin
      t = {1'b0, 32'h100 + 32'(4*k), refmem[64+k]};
      total++; if (l2_log[k] !== t) begin bad++; $display("FAIL fill_l2_txn%0d got %h want %h", k, l2_log[k], t); end
    end
  endtask

  task automatic test_hit;
    logic [31:0] ta [5] = '{32'h103, 32'h102, 32'h103, 32'h100, 32'h101};
    memory_operation_size_e ts [5] = '{BYTE, HALF, HALF, BYTE, WORD};
    logic [31:0] te [5] = '{32'h0000_00DE, 32'h0000_DEAD, 32'h0000_DEAD, 32'h0000_00EF, 32'hDEAD_BEEF};
    int cyc; logic [31:0] rd, e; bit ok;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(te[i]);
      drive_req(ta[i], ts[i], LOAD, 32'h0, cyc, rd, ok);
      e = exp_q.pop_front();
      total++; if (!ok || rd !== e || cyc !== 0) begin bad++; $display("FAIL hit%0d got %h cyc %0d want %h cyc 0", i, rd, cyc, e); end
    end
  endtask

  task automatic test_store;
    logic [31:0] sa [4] = '{32'h101, 32'h104, 32'h10B, 32'h10E};
    memory_operation_size_e ss [4] = '{BYTE, WORD, HALF, BYTE};
    logic [31:0] sd [4] = '{32'h0000_0055, 32'h1234_5678, 32'h0000_ABCD, 32'hFFFF_FF77};
    logic [31:0] la [4] = '{32'h100, 32'h104, 32'h108, 32'h10E};
    memory_operation_size_e ls [4] = '{WORD, WORD, WORD, BYTE};
    int cyc; logic [31:0] rd, e; bit ok;
    l2_log.delete();
    for (int i = 0; i < 4; i++) begin
      ref_store(sa[i], ss[i], sd[i]);
      drive_req(sa[i], ss[i], STORE, sd[i], cyc, rd, ok);
      total++; if (!ok || cyc !== 0) begin bad++; $display("FAIL store%0d cyc got %0d want 0 ok=%0d", i, cyc, ok); end
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ref_load(la[i], ls[i]));
      drive_req(la[i], ls[i], LOAD, 32'h0, cyc, rd, ok);
      e = exp_q.pop_front();
      total++; if (!ok || rd !== e || cyc !== 0) begin bad++; $display("FAIL store_readback%0d got %h want %h cyc %0d", i, rd, e, cyc); end
    end
    total++; if (refmem[64] !== 32'hDEAD55EF) begin bad++; $display("FAIL store_model got %h want deadbeef-with-55", refmem[64]); end
    total++; if (l2_log.size() !== 0) begin bad++; $display("FAIL store_l2_traffic got %0d want 0", l2_log.size()); end
  endtask

  task automatic test_writeback;
    int cyc; logic [31:0] rd, e; bit ok; l2_txn_t t;
    logic [31:0] victim [4];
    for (int k = 0; k < 4; k++) victim[k] = refmem[64+k];
    l2_log.delete();
    exp_q.push_back(ref_load(32'h200, WORD));
    drive_req(32'h200, WORD, LOAD, 32'h0, cyc, rd, ok);
    e = exp_q.pop_front();
    total++; if (!ok || rd !== e) begin bad++; $display("FAIL wb_data got %h want %h", rd, e); end
    total++; if (cyc !== 9) begin bad++; $display("FAIL wb_latency got %0d want 9", cyc); end
    total++; if (l2_log.size() !== 8) begin bad++; $display("FAIL wb_l2_count got %0d want 8", l2_log.size()); end
    if (l2_log.size() > 0) begin
      total++; if (l2_log[0].data !== 32'hDEAD55EF) begin bad++; $display("FAIL wb_first_word got %h want dead55ef", l2_log[0].data); end
    end
    for (int k = 0; k < 8 && k < l2_log.size(); k++) begin
      if (k < 4) t = {1'b1, 32'h100 + 32'(4*k), victim[k]};
      else       t = {1'b0, 32'h200 + 32'(4*(k-4)), refmem[128+k-4]};
      total++; if (l2_log[k] !== t) begin bad++; $display("FAIL wb_l2_txn%0d got %h want %h", k, l2_log[k], t); end
    end
  endtask

  task automatic test_idle_and_drop;
    int cyc; logic [31:0] rd, e; bit ok;
    pipe_req_valid = 1'b0;
    pipe_req_address = 32'h700;
    for (int i = 0; i < 3; i++) begin
      #4;
      total++; if (pipe_req_fulfilled !== 1'b0 || l2_req_valid !== 1'b0) begin bad++; $display("FAIL idle%0d got ful=%b l2v=%b want 0 0", i, pipe_req_fulfilled, l2_req_valid); end
      @(negedge clk);
    end
    l2_log.delete();
    pipe_req_address = 32'h300;
    pipe_req_size    = WORD;
    pipe_req_type    = LOAD;
    pipe_req_valid   = 1'b1;
    #4;
    total++; if (pipe_req_fulfilled !== 1'b0) begin bad++; $display("FAIL drop_miss_fulfilled got %b want 0", pipe_req_fulfilled); end
    @(negedge clk);
    pipe_req_valid = 1'b0;
    pipe_req_address = 32'h1F00;
    repeat (6) @(negedge clk);
    total++; if (l2_log.size() !== 4 || l2_log[0].addr !== 32'h300 || l2_log[3].addr !== 32'h30C)
      begin bad++; $display("FAIL drop_fill got n=%0d want 4 loads 300..30c", l2_log.size()); end
    exp_q.push_back(ref_load(32'h304, WORD));
    drive_req(32'h304, WORD, LOAD, 32'h0, cyc, rd, ok);
    e = exp_q.pop_front();
    total++; if (!ok || rd !== e || cyc !== 0) begin bad++; $display("FAIL drop_hit got %h cyc %0d want %h cyc 0", rd, cyc, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ba [4] = '{32'h300, 32'h306, 32'h306, 32'h30D};
    memory_operation_size_e bs [4] = '{WORD, HALF, HALF, BYTE};
    memory_operation_e bt [4] = '{LOAD, STORE, LOAD, LOAD};
    int cyc, sum; logic [31:0] rd, e; bit ok; time t0;
    sum = 0;
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      if (bt[i] == STORE) ref_store(ba[i], bs[i], 32'h0000_1234);
      else exp_q.push_back(ref_load(ba[i], bs[i]));
      drive_req(ba[i], bs[i], bt[i], 32'h0000_1234, cyc, rd, ok);
      sum += cyc + (ok ? 0 : 100);
      if (bt[i] == LOAD) begin
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL b2b%0d got %h want %h", i, rd, e); end
      end
    end
    total++; if (sum !== 0 || ($time - t0) !== 40) begin bad++; $display("FAIL b2b_timing got stall %0d span %0t want 0 40", sum, $time - t0); end
  endtask

  task automatic test_reset_mid_miss;
    int cyc; logic [31:0] rd, e; bit ok, wb_ok;
    l2_log.delete();
    pipe_req_address = 32'h400;
    pipe_req_size    = WORD;
    pipe_req_type    = LOAD;
    pipe_req_valid   = 1'b1;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (l2_req_valid !== 1'b0 || pipe_req_fulfilled !== 1'b0) begin bad++; $display("FAIL rst_mid got l2v=%b ful=%b want 0 0", l2_req_valid, pipe_req_fulfilled); end
    wb_ok = (l2_log.size() >= 4);
    for (int k = 0; k < 4 && k < l2_log.size(); k++)
      if (l2_log[k] !== {1'b1, 32'h300 + 32'(4*k), refmem[192+k]}) wb_ok = 1'b0;
    total++; if (!wb_ok) begin bad++; $display("FAIL rst_mid_writeback got n=%0d want 4 stores 300..30c", l2_log.size()); end
    pipe_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(ref_load(32'h400, WORD));
    drive_req(32'h400, WORD, LOAD, 32'h0, cyc, rd, ok);
    e = exp_q.pop_front();
    total++; if (!ok || rd !== e || cyc !== 5) begin bad++; $display("FAIL rst_mid_reload got %h cyc %0d want %h cyc 5", rd, cyc, e); end
    exp_q.push_back(ref_load(32'h304, WORD));
    drive_req(32'h304, WORD, LOAD, 32'h0, cyc, rd, ok);
    e = exp_q.pop_front();
    total++; if (!ok || rd !== e || cyc !== 5) begin bad++; $display("FAIL rst_mid_old_line got %h cyc %0d want %h cyc 5", rd, cyc, e); end
  endtask

  task automatic test_random;
    int cyc; logic [31:0] a, rd, e; bit ok;
    memory_operation_size_e sz;
    for (int i = 0; i < 2048; i++) begin
      a  = ($urandom_range(0, 2047) << 2) | $urandom_range(0, 3);
      sz = memory_operation_size_e'($urandom_range(0, 2));
      exp_q.push_back(ref_load(a, sz));
      drive_req(a, sz, LOAD, 32'h0, cyc, rd, ok);
      e = exp_q.pop_front();
      total++; if (!ok || rd !== e) begin bad++; $display("FAIL rand%0d addr %h size %0d got %h want %h ok=%0d", i, a, sz, rd, e, ok); end
    end
  endtask

  initial begin
    reset              = 1'b0;
    pipe_req_valid     = 1'b0;
    pipe_req_address   = '0;
    pipe_req_size      = WORD;
    pipe_req_type      = LOAD;
    pipe_word_to_store = '0;
    for (int i = 0; i < 2048; i++) refmem[i] = pat(i);
    refmem[64] = 32'hDEADBEEF;
    test_reset;
    test_fill;
    test_hit;
    test_store;
    test_writeback;
    test_idle_and_drop;
    test_back_to_back;
    test_reset_mid_miss;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
